// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and helpers for the multi-port register file.
// Holds the sweep state enum, depth helper and write-port arbitration.
package regfile_pkg;

  typedef enum logic {CLEAR, RUN} state_t;

  localparam int MAX_NWR = 8;
  localparam int MAX_AW  = 16;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } win_t;

  function automatic int depth(input int aw);
    return 1 << aw;
  endfunction

  // highest-numbered enabled port matching the address wins
  function automatic win_t wr_win(
    input logic [MAX_NWR-1:0]             en,
    input logic [MAX_NWR-1:0][MAX_AW-1:0] wa,
    input logic [MAX_AW-1:0]              a
  );
    win_t r;
    r = '0;
    for (int j = 0; j < MAX_NWR; j++) begin
      if (en[j] && wa[j] == a) begin
        r.hit = 1'b1;
        r.idx = 3'(j);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// regfile_clear_fsm: post-reset sweep that zeroes every entry once.
// Drives the clear write port and ready.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  output logic              o_ready,
  output logic              o_clr_we,
  output logic [ADDR_W-1:0] o_clr_addr
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] w_ptr_nxt;

  // state and sweep pointer register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= CLEAR;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // sweep sequencing and outputs
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    o_ready     = 1'b0;
    o_clr_we    = 1'b0;
    unique case (r_state)
      CLEAR: begin
        o_clr_we  = 1'b1;
        w_ptr_nxt = r_ptr + 1'b1;
        if (r_ptr == '1) w_state_nxt = RUN;
      end
      RUN: o_ready = 1'b1;
      default: w_state_nxt = CLEAR;
    endcase
  end

  assign o_clr_addr = r_ptr;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised NRD-read / NWR-write register file.
// Entry 0 reads as zero; optional same-cycle write bypass.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter int BYPASS = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  output logic                  ready,
  input  logic [NRD*ADDR_W-1:0] raddr,
  output logic [NRD*DATA_W-1:0] rdata,
  input  logic [NWR-1:0]        we,
  input  logic [NWR*ADDR_W-1:0] waddr,
  input  logic [NWR*DATA_W-1:0] wdata
);

  localparam int DEPTH = depth(ADDR_W);

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_run;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;

  regfile_clear_fsm #(
    .ADDR_W (ADDR_W)
  ) u_fsm (
    .i_clk      (clk),
    .i_rst_n    (resetn),
    .o_ready    (w_run),
    .o_clr_we   (w_clr_we),
    .o_clr_addr (w_clr_addr)
  );

  assign ready = w_run;

  logic [NWR-1:0] w_wen;

  for (genvar j = 0; j < NWR; j++) begin : g_wr
    assign w_wen[j] = w_run & we[j] &
                      (waddr[j*ADDR_W +: ADDR_W] != '0);
  end

  logic [MAX_NWR-1:0]             w_en_x;
  logic [MAX_NWR-1:0][MAX_AW-1:0] w_wa_x;

  // widen write ports to the arbitration helper's shape
  always_comb begin
    w_en_x = '0;
    w_wa_x = '0;
    for (int j = 0; j < NWR; j++) begin
      w_en_x[j] = w_wen[j];
      w_wa_x[j] = MAX_AW'(waddr[j*ADDR_W +: ADDR_W]);
    end
  end

  // array update: sweep first, then ports in rising order
  always_ff @(posedge clk) begin
    if (w_clr_we) r_mem[w_clr_addr] <= '0;
    for (int j = 0; j < NWR; j++) begin
      if (w_wen[j])
        r_mem[waddr[j*ADDR_W +: ADDR_W]] <=
          wdata[j*DATA_W +: DATA_W];
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    win_t              w_win;
    logic [DATA_W-1:0] w_byp;
    logic [DATA_W-1:0] w_rd;

    assign w_ra  = raddr[i*ADDR_W +: ADDR_W];
    assign w_win = wr_win(w_en_x, w_wa_x, MAX_AW'(w_ra));

    // select the winning port's write data
    always_comb begin
      w_byp = '0;
      for (int j = 0; j < NWR; j++) begin
        if (int'(w_win.idx) == j)
          w_byp = wdata[j*DATA_W +: DATA_W];
      end
    end

    // read mux: zero during sweep and for r0
    always_comb begin
      if (!w_run || w_ra == '0)
        w_rd = '0;
      else if (BYPASS != 0 && w_win.hit)
        w_rd = w_byp;
      else
        w_rd = r_mem[w_ra];
    end

    assign rdata[i*DATA_W +: DATA_W] = w_rd;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks on three register file configurations.
// Expected values queue at drive time and pop at sample time.
module tb_regfile_mp;

  logic clk;
  logic resetn;

  logic        a_ready;
  logic [9:0]  a_raddr;
  logic [63:0] a_rdata;
  logic [1:0]  a_we;
  logic [9:0]  a_waddr;
  logic [63:0] a_wdata;

  logic        b_ready;
  logic [9:0]  b_raddr;
  logic [63:0] b_rdata;
  logic [0:0]  b_we;
  logic [4:0]  b_waddr;
  logic [31:0] b_wdata;

  logic         c_ready;
  logic [23:0]  c_raddr;
  logic [255:0] c_rdata;
  logic [1:0]   c_we;
  logic [11:0]  c_waddr;
  logic [127:0] c_wdata;

  regfile_mp #(
    .DATA_W(32), .ADDR_W(5), .NRD(2), .NWR(2), .BYPASS(1)
  ) u_a (
    .clk(clk), .resetn(resetn), .ready(a_ready),
    .raddr(a_raddr), .rdata(a_rdata), .we(a_we),
    .waddr(a_waddr), .wdata(a_wdata)
  );

  regfile_mp #(
    .DATA_W(32), .ADDR_W(5), .NRD(2), .NWR(1), .BYPASS(0)
  ) u_b (
    .clk(clk), .resetn(resetn), .ready(b_ready),
    .raddr(b_raddr), .rdata(b_rdata), .we(b_we),
    .waddr(b_waddr), .wdata(b_wdata)
  );

  regfile_mp #(
    .DATA_W(64), .ADDR_W(6), .NRD(4), .NWR(2), .BYPASS(1)
  ) u_c (
    .clk(clk), .resetn(resetn), .ready(c_ready),
    .raddr(c_raddr), .rdata(c_rdata), .we(c_we),
    .waddr(c_waddr), .wdata(c_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        tag;
    logic [255:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_checks;
  int   n_errors;

  task automatic want(input string tag, input logic [255:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic got(input logic [255:0] obs);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_errors++;
      $error("FAIL scoreboard_empty observed=%0h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.v) else begin
        n_errors++;
        $error("FAIL %s observed=%0h expected=%0h",
               e.tag, obs, e.v);
      end
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    resetn  = 1'b0;
    a_raddr = '0; a_we = '0; a_waddr = '0; a_wdata = '0;
    b_raddr = '0; b_we = '0; b_waddr = '0; b_wdata = '0;
    c_raddr = '0; c_we = '0; c_waddr = '0; c_wdata = '0;

    tick;
    tick;
    a_raddr = {5'd3, 5'd5};
    want("rst_a_ready", 256'(1'b0));
    want("rst_b_ready", 256'(1'b0));
    want("rst_c_ready", 256'(1'b0));
    want("rst_a_rdata", 256'(64'd0));
    @(negedge clk);
    got(256'(a_ready));
    got(256'(b_ready));
    got(256'(c_ready));
    got(256'(a_rdata));

    // release reset; we pulses on B must be ignored in CLEAR
    tick;
    resetn  = 1'b1;
    b_raddr = {5'd9, 5'd5};
    b_we    = 1'b1;
    b_waddr = 5'd1;
    b_wdata = 32'hDEAD_BEEF;
    for (int k = 1; k <= 64; k++) begin
      tick;
      b_we    = 1'(k <= 31);
      b_waddr = 5'(k);
      want($sformatf("sweep_a_ready_%0d", k), 256'(k >= 32));
      want($sformatf("sweep_c_ready_%0d", k), 256'(k >= 64));
      got(256'(a_ready));
      got(256'(c_ready));
      if (k == 31 || k == 32) begin
        want($sformatf("sweep_b_ready_%0d", k), 256'(k >= 32));
        got(256'(b_ready));
      end
      if (k < 32) begin
        want($sformatf("clear_b_rdata_%0d", k), 256'(64'd0));
        got(256'(b_rdata));
      end
    end
    b_we = 1'b0;

    for (int a = 0; a < 32; a++) begin
      tick;
      b_raddr = {5'(31 - a), 5'(a)};
      want($sformatf("swept_b_%0d", a), 256'(64'd0));
      @(negedge clk);
      got(256'(b_rdata));
    end

    // no bypass: visible the cycle after the write edge
    tick;
    b_we    = 1'b1;
    b_waddr = 5'd5;
    b_wdata = 32'h1234_5678;
    b_raddr = {5'd0, 5'd5};
    want("nobyp_same_cycle", 256'(32'd0));
    @(negedge clk);
    got(256'(b_rdata[31:0]));
    tick;
    b_we = 1'b0;
    want("nobyp_next_cycle", 256'(32'h1234_5678));
    @(negedge clk);
    got(256'(b_rdata[31:0]));

    // bypass: visible in the write cycle
    tick;
    a_we    = 2'b01;
    a_waddr = {5'd0, 5'd5};
    a_wdata = {32'd0, 32'h1234_5678};
    a_raddr = {5'd0, 5'd5};
    want("byp_same_cycle", 256'({32'd0, 32'h1234_5678}));
    @(negedge clk);
    got(256'(a_rdata));
    tick;
    a_we = 2'b00;
    want("byp_after", 256'(32'h1234_5678));
    @(negedge clk);
    got(256'(a_rdata[31:0]));

    // register zero on both ports
    tick;
    a_we    = 2'b11;
    a_waddr = {5'd0, 5'd0};
    a_wdata = {32'hFFFF_FFFF, 32'hFFFF_FFFF};
    a_raddr = {5'd0, 5'd0};
    want("r0_same_cycle", 256'(64'd0));
    @(negedge clk);
    got(256'(a_rdata));
    tick;
    a_we = 2'b00;
    want("r0_after", 256'(64'd0));
    @(negedge clk);
    got(256'(a_rdata));

    // write conflict on r7: port 1 wins
    tick;
    a_we    = 2'b11;
    a_waddr = {5'd7, 5'd7};
    a_wdata = {32'h0000_BBBB, 32'hAAAA_0000};
    a_raddr = {5'd5, 5'd7};
    want("conflict_byp", 256'({32'h1234_5678, 32'h0000_BBBB}));
    @(negedge clk);
    got(256'(a_rdata));
    tick;
    a_we = 2'b00;
    want("conflict_stored", 256'(32'h0000_BBBB));
    @(negedge clk);
    got(256'(a_rdata[31:0]));

    // wide configuration, four read ports at once
    tick;
    c_we    = 2'b11;
    c_waddr = {6'd1, 6'd63};
    c_wdata = {64'd1, 64'h0123_4567_89AB_CDEF};
    tick;
    c_waddr = {6'd0, 6'd32};
    c_wdata = {64'hFFFF_FFFF_FFFF_FFFF, 64'd2};
    tick;
    c_we    = 2'b00;
    c_raddr = {6'd0, 6'd32, 6'd1, 6'd63};
    want("c_port0_r63", 256'(64'h0123_4567_89AB_CDEF));
    want("c_port1_r1", 256'(64'd1));
    want("c_port2_r32", 256'(64'd2));
    want("c_port3_r0", 256'(64'd0));
    @(negedge clk);
    got(256'(c_rdata[63:0]));
    got(256'(c_rdata[127:64]));
    got(256'(c_rdata[191:128]));
    got(256'(c_rdata[255:192]));

    // fill B with a marker pattern
    for (int a = 1; a < 32; a++) begin
      tick;
      b_we    = 1'b1;
      b_waddr = 5'(a);
      b_wdata = 32'hDEAD_BEEF;
    end
    tick;
    b_we    = 1'b0;
    b_raddr = {5'd31, 5'd17};
    want("fill_b", 256'({32'hDEAD_BEEF, 32'hDEAD_BEEF}));
    @(negedge clk);
    got(256'(b_rdata));

    // reset, then reset again ten cycles into the sweep
    tick;
    resetn = 1'b0;
    tick;
    tick;
    resetn = 1'b1;
    for (int k = 0; k < 10; k++) tick;
    resetn = 1'b0;
    b_we    = 1'b1;
    b_waddr = 5'd3;
    b_wdata = 32'h5555_AAAA;
    want("midreset_b_ready", 256'(1'b0));
    @(negedge clk);
    got(256'(b_ready));
    tick;
    tick;
    resetn = 1'b1;
    b_we   = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      tick;
      want($sformatf("resweep_b_ready_%0d", k), 256'(k >= 32));
      want($sformatf("resweep_a_ready_%0d", k), 256'(k >= 32));
      got(256'(b_ready));
      got(256'(a_ready));
    end
    for (int a = 0; a < 32; a++) begin
      tick;
      b_raddr = {5'(31 - a), 5'(a)};
      want($sformatf("reswept_b_%0d", a), 256'(64'd0));
      @(negedge clk);
      got(256'(b_rdata));
    end
    tick;
    a_raddr = {5'd5, 5'd7};
    want("reswept_a_r7_r5", 256'(64'd0));
    @(negedge clk);
    got(256'(a_rdata));

    if (sb.size() != 0) begin
      n_errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0",
             sb.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port general-purpose register file for the pipelined LoongArch core, the successor to the fixed 32×32, 2R/1W register file.
- Configurable data width, depth, and read/write port counts.
- Writes commit on the rising edge.
- Optional same-cycle write-to-read bypass and deterministic priority between simultaneous writes.
- After reset, a hardware sweep state machine zeroes every entry, so the array itself needs no reset. Decode/writeback stages connect to it directly.

## Interface
- DATA_W, 32: entry width in bits.
- ADDR_W, 5: address width; depth = 2**ADDR_W.
- NRD, 2: number of read ports (≥1).
- NWR, 1: number of write ports (≥1).
- BYPASS, 1: 1 = reads see same-cycle write data; 0 = reads see array contents only.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- ready  out  1  1 once the post-reset clear sweep is complete.
- raddr  in  NRD*ADDR_W  read addresses; port i at [i*ADDR_W +: ADDR_W].
- rdata  out  NRD*DATA_W  read data; port i at [i*DATA_W +: DATA_W].
- we  in  NWR  per-port write enable, active high.
- waddr  in  NWR*ADDR_W  write addresses, packed as raddr.
- wdata  in  NWR*DATA_W  write data, packed as rdata.

## Operation
- **Entry 0** is hardwired zero. Writes to address 0 are dropped. Reads of address 0 return 0 regardless of bypass.
- **FSM states:** CLEAR, RUN. It holds a clear pointer `clr_ptr` of ADDR_W bits.
- **resetn low (asynchronous):**
  - state ← CLEAR, clr_ptr ← 0, ready ← 0.
  - Array contents are not reset asynchronously.
- **CLEAR:**
  - Each cycle, entry[clr_ptr] ← 0 and clr_ptr ← clr_ptr+1.
  - When clr_ptr == 2**ADDR_W−1, that entry is written and the state goes to RUN.
  - All `we` are ignored.
  - All rdata = 0.
- **RUN:**
  - Each port with we[j]=1 and waddr[j]≠0 writes wdata[j] to entry[waddr[j]] at the rising edge.
  - ready = 1.
- **Write conflict:** when several enabled ports target the same address in one cycle, the highest-numbered port wins, and only its data is stored.
- **Reads** are combinational, from raddr to rdata.
- **Bypass (BYPASS=1, RUN only):** if any enabled write port targets raddr[i]≠0 this cycle, rdata[i] = the winning port's wdata. Otherwise rdata[i] = entry[raddr[i]].
- **No bypass (BYPASS=0):** rdata[i] = entry[raddr[i]]. New data becomes visible the cycle after the write edge.
- **Reset mid-sweep or mid-operation:** the sweep restarts from entry 0. Any write presented in the same cycle that resetn falls is discarded.

## Timing
- **Reset values:** ready = 0. rdata = 0 on all ports while in CLEAR.
- **Clear latency:** ready rises after exactly 2**ADDR_W rising edges following resetn deassertion. It is 1 in the cycle after the edge that clears the last entry. The default configuration takes 32 cycles.
- **Write latency:** the write commits at edge t. With BYPASS=0 it is visible on rdata from cycle t+1. With BYPASS=1 it is visible in cycle t itself, combinationally.
- **Read latency:** 0 cycles; purely combinational from raddr, we, waddr, and wdata.
- **resetn:** no synchronous dependency on assertion. Deassertion is assumed already synchronised upstream in the SoC reset tree.

## Structure
- **Package `regfile_pkg`:**
  - State enum {CLEAR, RUN}.
  - Localparam helper for depth (2**ADDR_W).
  - Function that selects the winning write port for an address (highest index with we & address match).
- **Sub-module `regfile_clear_fsm`:**
  - Owns state, clr_ptr, and ready.
  - Outputs the clear write enable and clear address.
  - The top muxes the clear write in ahead of the normal write ports.
- The array is a plain reg array without reset.
- Read and bypass muxing are generated per read port; write decode is generated per write port.

## Test plan
- **Reset sweep:** deassert resetn with default parameters, pre-filling the array via backdoor with 0xDEADBEEF.
  - ready = 0 for 32 cycles, then 1.
  - Every address reads 0.
  - `we` pulses during CLEAR leave the array unchanged.
- **Basic write/read:** in RUN, write 0x12345678 to r5.
  - With BYPASS=0: rdata0 (raddr0=5) = 0 in the write cycle and 0x12345678 on the next cycle.
  - With BYPASS=1: rdata0 = 0x12345678 in the same cycle.
- **Register zero:** write 0xFFFFFFFF to r0 → all ports read 0 from r0, in the same cycle and after.
- **Write conflict:** NWR=2, both ports write r7 with 0xAAAA0000 (port 0) and 0x0000BBBB (port 1) → r7 = 0x0000BBBB. Bypass read of r7 returns 0x0000BBBB.
- **Mid-sweep reset:** assert resetn at sweep cycle 10, hold 2 cycles, then release → ready stays 0 for a full 32 cycles after release, and entries 0..31 all read 0.
- **Parametrised config:** DATA_W=64, ADDR_W=6, NRD=4, NWR=2.
  - Ready after 64 cycles.
  - All 4 read ports simultaneously return the values written to r63, r1, r32, and r0 (0x0123456789ABCDEF, 1, 2, 0).
